// File: rtl/ram_port_arbiter_if.sv
// Command/data bundle between two RAM requesters, the arbiter and the single-port RAM.
// slave: arbiter side; master: requester/RAM environment side.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_SIZE = 8
);
    localparam int unsigned CW = ADDR_SIZE + 2;

    logic [CW-1:0] req0_din;
    logic          req0_valid;
    logic          req0_ready;
    logic [7:0]    req0_dout;
    logic          req0_dout_valid;

    logic [CW-1:0] req1_din;
    logic          req1_valid;
    logic          req1_ready;
    logic [7:0]    req1_dout;
    logic          req1_dout_valid;

    logic [CW-1:0] ram_din;
    logic          ram_rx_valid;
    logic [7:0]    ram_dout;
    logic          ram_tx_valid;

    logic          err_timeout;

    modport slave (
        input  req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
        output req0_ready, req0_dout, req0_dout_valid,
        output req1_ready, req1_dout, req1_dout_valid,
        output ram_din, ram_rx_valid, err_timeout
    );

    modport master (
        output req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
        input  req0_ready, req0_dout, req0_dout_valid,
        input  req1_ready, req1_dout, req1_dout_valid,
        input  ram_din, ram_rx_valid, err_timeout
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between two command requesters,
// holding ownership across addr->data pairs and routing read data back to the owner.
module ram_port_arbiter #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave bus
);
    localparam int unsigned CW = ADDR_SIZE + 2;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_WR   = 2'd1,
        LOCK_RD   = 2'd2,
        WAIT_DATA = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_owner;
    logic            r_last_grant;
    logic [TW-1:0]   r_timer;

    logic            w_rdy0;
    logic            w_rdy1;
    logic            w_acc;
    logic [CW-1:0]   w_cmd;
    logic [1:0]      w_op;
    logic            w_timeout;
    state_t          w_cmd_state;

    // Grant: free choice in IDLE, owner-only while locked, nobody while awaiting data
    always_comb begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        w_rdy0 = r_last_grant;
                        w_rdy1 = ~r_last_grant;
                    end else begin
                        w_rdy0 = bus.req0_valid;
                        w_rdy1 = bus.req1_valid;
                    end
                end
                LOCK_WR, LOCK_RD: begin
                    w_rdy0 = bus.req0_valid & ~r_owner;
                    w_rdy1 = bus.req1_valid & r_owner;
                end
                default: begin
                    w_rdy0 = 1'b0;
                    w_rdy1 = 1'b0;
                end
            endcase
        end
    end

    assign w_acc          = w_rdy0 | w_rdy1;
    assign w_cmd          = w_rdy1 ? bus.req1_din : bus.req0_din;
    assign w_op           = w_cmd[CW-1 -: 2];
    assign w_timeout      = (r_timer == TW'(TIMEOUT));
    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;

    always_comb begin
        w_cmd_state = IDLE;
        case (w_op)
            2'b00:   w_cmd_state = LOCK_WR;
            2'b01:   w_cmd_state = IDLE;
            2'b10:   w_cmd_state = LOCK_RD;
            default: w_cmd_state = WAIT_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state             <= IDLE;
            r_owner             <= 1'b0;
            r_last_grant        <= 1'b1;
            r_timer             <= '0;
            bus.ram_din         <= '0;
            bus.ram_rx_valid    <= 1'b0;
            bus.req0_dout       <= 8'h00;
            bus.req0_dout_valid <= 1'b0;
            bus.req1_dout       <= 8'h00;
            bus.req1_dout_valid <= 1'b0;
            bus.err_timeout     <= 1'b0;
        end else begin
            bus.ram_rx_valid    <= w_acc;
            bus.req0_dout_valid <= 1'b0;
            bus.req1_dout_valid <= 1'b0;
            bus.err_timeout     <= 1'b0;
            if (w_acc) begin
                bus.ram_din <= w_cmd;
            end

            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_acc) begin
                        r_owner      <= w_rdy1;
                        r_last_grant <= w_rdy1;
                        r_state      <= w_cmd_state;
                    end
                end
                LOCK_WR, LOCK_RD: begin
                    if (w_acc) begin
                        r_timer <= '0;
                        r_state <= w_cmd_state;
                    end else if (w_timeout) begin
                        r_timer         <= '0;
                        r_owner         <= 1'b0;
                        r_state         <= IDLE;
                        bus.err_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    // Returning data takes priority over a simultaneous timeout
                    if (bus.ram_tx_valid) begin
                        if (r_owner) begin
                            bus.req1_dout       <= bus.ram_dout;
                            bus.req1_dout_valid <= 1'b1;
                        end else begin
                            bus.req0_dout       <= bus.ram_dout;
                            bus.req0_dout_valid <= 1'b1;
                        end
                        r_timer <= '0;
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        r_timer         <= '0;
                        r_owner         <= 1'b0;
                        r_state         <= IDLE;
                        bus.err_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: locking, round-robin, read return, timeout, reset.
module tb_ram_port_arbiter;
    localparam int unsigned ADDR_SIZE = 8;
    localparam int unsigned TIMEOUT   = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_SIZE(ADDR_SIZE)) u_if ();

    ram_port_arbiter #(.ADDR_SIZE(ADDR_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.req0_din     = '0;
        u_if.req0_valid   = 1'b0;
        u_if.req1_din     = '0;
        u_if.req1_valid   = 1'b0;
        u_if.ram_dout     = 8'h00;
        u_if.ram_tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [30:0] outs;
        rst_n = 1'b0;
        idle_inputs();
        u_if.req0_valid = 1'b1;
        u_if.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready: got %b exp 00", {u_if.req0_ready, u_if.req1_ready});
        end
        tick();
        tick();
        outs = {u_if.ram_din, u_if.ram_rx_valid, u_if.req0_dout, u_if.req0_dout_valid,
                u_if.req1_dout, u_if.req1_dout_valid, u_if.err_timeout};
        n_cmp++;
        if (outs !== 31'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h exp 0", outs);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lock_write();
        u_if.req0_din   = 10'h012;
        u_if.req0_valid = 1'b1;
        u_if.req1_din   = 10'h034;
        u_if.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL lock_first_grant: got %b exp 10", {u_if.req0_ready, u_if.req1_ready});
        end
        tick();
        n_cmp++;
        if ({u_if.ram_rx_valid, u_if.ram_din} !== {1'b1, 10'h012}) begin
            n_err++;
            $display("FAIL lock_fwd_addr: got %h exp %h", {u_if.ram_rx_valid, u_if.ram_din}, {1'b1, 10'h012});
        end
        u_if.req0_din = 10'h1AB;
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL lock_hold: got %b exp 10", {u_if.req0_ready, u_if.req1_ready});
        end
        tick();
        n_cmp++;
        if ({u_if.ram_rx_valid, u_if.ram_din} !== {1'b1, 10'h1AB}) begin
            n_err++;
            $display("FAIL lock_fwd_data: got %h exp %h", {u_if.ram_rx_valid, u_if.ram_din}, {1'b1, 10'h1AB});
        end
        u_if.req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL lock_release: got %b exp 01", {u_if.req0_ready, u_if.req1_ready});
        end
        tick();
        n_cmp++;
        if ({u_if.ram_rx_valid, u_if.ram_din} !== {1'b1, 10'h034}) begin
            n_err++;
            $display("FAIL lock_req1_addr: got %h exp %h", {u_if.ram_rx_valid, u_if.ram_din}, {1'b1, 10'h034});
        end
        u_if.req1_din = 10'h100;
        tick();
        u_if.req1_valid = 1'b0;
        tick();
        n_cmp++;
        if ({u_if.ram_rx_valid, u_if.ram_din} !== {1'b0, 10'h100}) begin
            n_err++;
            $display("FAIL lock_rx_idle_hold: got %h exp %h", {u_if.ram_rx_valid, u_if.ram_din}, {1'b0, 10'h100});
        end
    endtask

    task automatic test_read_return();
        u_if.req1_din   = 10'h212;
        u_if.req1_valid = 1'b1;
        tick();
        n_cmp++;
        if ({u_if.ram_rx_valid, u_if.ram_din} !== {1'b1, 10'h212}) begin
            n_err++;
            $display("FAIL rd_fwd_addr: got %h exp %h", {u_if.ram_rx_valid, u_if.ram_din}, {1'b1, 10'h212});
        end
        u_if.req1_din = 10'h300;
        tick();
        u_if.req1_valid = 1'b0;
        n_cmp++;
        if ({u_if.ram_rx_valid, u_if.ram_din} !== {1'b1, 10'h300}) begin
            n_err++;
            $display("FAIL rd_fwd_data: got %h exp %h", {u_if.ram_rx_valid, u_if.ram_din}, {1'b1, 10'h300});
        end
        u_if.req0_din   = 10'h155;
        u_if.req0_valid = 1'b1;
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL rd_wait_stall: got %b exp 00", {u_if.req0_ready, u_if.req1_ready});
        end
        u_if.ram_dout     = 8'hAB;
        u_if.ram_tx_valid = 1'b1;
        tick();
        u_if.ram_tx_valid = 1'b0;
        n_cmp++;
        if ({u_if.req1_dout, u_if.req1_dout_valid, u_if.req0_dout, u_if.req0_dout_valid} !== {8'hAB, 1'b1, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL rd_return: got %h exp %h",
                     {u_if.req1_dout, u_if.req1_dout_valid, u_if.req0_dout, u_if.req0_dout_valid},
                     {8'hAB, 1'b1, 8'h00, 1'b0});
        end
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL rd_idle_after: got %b exp 10", {u_if.req0_ready, u_if.req1_ready});
        end
        tick();
        u_if.req0_valid = 1'b0;
        n_cmp++;
        if ({u_if.req1_dout_valid, u_if.req0_dout_valid, u_if.ram_rx_valid, u_if.ram_din} !== {1'b0, 1'b0, 1'b1, 10'h155}) begin
            n_err++;
            $display("FAIL rd_pulse_once: got %h exp %h",
                     {u_if.req1_dout_valid, u_if.req0_dout_valid, u_if.ram_rx_valid, u_if.ram_din},
                     {1'b0, 1'b0, 1'b1, 10'h155});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy;
        logic [9:0] exp_cmd;
        do_reset();
        u_if.req0_din   = 10'h101;
        u_if.req1_din   = 10'h102;
        u_if.req0_valid = 1'b1;
        u_if.req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_cmd = (i % 2 == 0) ? 10'h101 : 10'h102;
            #1;
            n_cmp++;
            if ({u_if.req0_ready, u_if.req1_ready} !== exp_rdy) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b exp %b", i, {u_if.req0_ready, u_if.req1_ready}, exp_rdy);
            end
            tick();
            n_cmp++;
            if ({u_if.ram_rx_valid, u_if.ram_din} !== {1'b1, exp_cmd}) begin
                n_err++;
                $display("FAIL rr_fwd[%0d]: got %h exp %h", i, {u_if.ram_rx_valid, u_if.ram_din}, {1'b1, exp_cmd});
            end
        end
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        // Last grant went to req1, so req0 wins this tie
        u_if.req0_din   = 10'h020;
        u_if.req1_din   = 10'h140;
        u_if.req0_valid = 1'b1;
        u_if.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL to_grant: got %b exp 10", {u_if.req0_ready, u_if.req1_ready});
        end
        tick();
        u_if.req0_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if ({u_if.err_timeout, u_if.req1_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL to_early[%0d]: got %b exp 00", k, {u_if.err_timeout, u_if.req1_ready});
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({u_if.err_timeout, u_if.req1_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL to_fire: got %b exp 11", {u_if.err_timeout, u_if.req1_ready});
        end
        tick();
        u_if.req1_valid = 1'b0;
        n_cmp++;
        if ({u_if.err_timeout, u_if.ram_rx_valid, u_if.ram_din} !== {1'b0, 1'b1, 10'h140}) begin
            n_err++;
            $display("FAIL to_after: got %h exp %h", {u_if.err_timeout, u_if.ram_rx_valid, u_if.ram_din},
                     {1'b0, 1'b1, 10'h140});
        end
    endtask

    task automatic test_timeout_data_wins();
        u_if.req0_din   = 10'h3C0;
        u_if.req0_valid = 1'b1;
        tick();
        u_if.req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if ({u_if.err_timeout, u_if.req0_dout_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL dw_pre: got %b exp 00", {u_if.err_timeout, u_if.req0_dout_valid});
        end
        u_if.ram_dout     = 8'h3C;
        u_if.ram_tx_valid = 1'b1;
        tick();
        u_if.ram_tx_valid = 1'b0;
        n_cmp++;
        if ({u_if.err_timeout, u_if.req0_dout_valid, u_if.req0_dout, u_if.req1_dout_valid} !== {1'b0, 1'b1, 8'h3C, 1'b0}) begin
            n_err++;
            $display("FAIL dw_deliver: got %h exp %h",
                     {u_if.err_timeout, u_if.req0_dout_valid, u_if.req0_dout, u_if.req1_dout_valid},
                     {1'b0, 1'b1, 8'h3C, 1'b0});
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [30:0] outs;
        u_if.req0_din   = 10'h300;
        u_if.req0_valid = 1'b1;
        tick();
        u_if.req0_valid = 1'b0;
        rst_n           = 1'b0;
        u_if.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL mr_ready_in_reset: got %b exp 00", {u_if.req0_ready, u_if.req1_ready});
        end
        tick();
        rst_n             = 1'b1;
        u_if.req1_valid   = 1'b0;
        u_if.ram_dout     = 8'h77;
        u_if.ram_tx_valid = 1'b1;
        tick();
        u_if.ram_tx_valid = 1'b0;
        outs = {u_if.ram_din, u_if.ram_rx_valid, u_if.req0_dout, u_if.req0_dout_valid,
                u_if.req1_dout, u_if.req1_dout_valid, u_if.err_timeout};
        n_cmp++;
        if (outs !== 31'h0) begin
            n_err++;
            $display("FAIL mr_outputs: got %h exp 0", outs);
        end
        u_if.req0_din   = 10'h101;
        u_if.req1_din   = 10'h102;
        u_if.req0_valid = 1'b1;
        u_if.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({u_if.req0_ready, u_if.req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL mr_next_grant: got %b exp 10", {u_if.req0_ready, u_if.req1_ready});
        end
        tick();
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        n_cmp++;
        if ({u_if.ram_rx_valid, u_if.ram_din} !== {1'b1, 10'h101}) begin
            n_err++;
            $display("FAIL mr_fwd: got %h exp %h", {u_if.ram_rx_valid, u_if.ram_din}, {1'b1, 10'h101});
        end
        tick();
    endtask

    task automatic test_stray_data();
        u_if.ram_dout     = 8'h55;
        u_if.ram_tx_valid = 1'b1;
        tick();
        u_if.ram_tx_valid = 1'b0;
        n_cmp++;
        if ({u_if.req0_dout_valid, u_if.req1_dout_valid, u_if.req0_dout, u_if.req1_dout} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
            n_err++;
            $display("FAIL stray_drop: got %h exp %h",
                     {u_if.req0_dout_valid, u_if.req1_dout_valid, u_if.req0_dout, u_if.req1_dout},
                     {1'b0, 1'b0, 8'h00, 8'h00});
        end
        tick();
        n_cmp++;
        if ({u_if.req0_dout_valid, u_if.req1_dout_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL stray_late: got %b exp 00", {u_if.req0_dout_valid, u_if.req1_dout_valid});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish exp finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_lock_write();
        test_read_return();
        test_round_robin();
        test_timeout();
        test_timeout_data_wins();
        test_reset_mid_wait();
        test_stray_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
